// File: rtl/muldiv_pkg.sv
// Shared definitions for muldiv_unit: op encodings, FSM states and the
// HI/LO update latency helper.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  // Edges from the accepting edge to the HI/LO update.
  function automatic int unsigned muldiv_latency(input int unsigned width);
    return width + 32'd1;
  endfunction

endpackage

// File: rtl/muldiv_abs.sv
// Conditional two's-complement negate, used for operand magnitudes and
// for the sign fix-up of results.
module muldiv_abs #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic             neg,
  output logic [WIDTH-1:0] y
);

  // Negate when requested, otherwise pass through.
  always_comb begin
    if (neg) begin
      y = ~a + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      y = a;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers and cancel support.
// The divide datapath is present only when MULDIV_DIV_EN is defined.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             cancel,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             ready,
  output logic             div_by_zero
);

  localparam int          CW       = $clog2(WIDTH);
  localparam int unsigned LAT      = muldiv_latency(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LAT - 32'd2);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 busy_q, busy_d, ready_q, ready_d;
  logic                 neg_lo_q, neg_lo_d;

  logic                 sgn_s, a_neg_s, b_neg_s;
  logic [WIDTH-1:0]     a_mag_s, b_mag_s;
  logic [WIDTH:0]       madd_s;
  logic [2*WIDTH-1:0]   mul_next_s, prod_s;

  assign sgn_s   = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg_s = sgn_s & srca[WIDTH-1];
  assign b_neg_s = sgn_s & srcb[WIDTH-1];

  muldiv_abs #(.WIDTH(WIDTH)) u_abs_a (.a(srca), .neg(a_neg_s), .y(a_mag_s));
  muldiv_abs #(.WIDTH(WIDTH)) u_abs_b (.a(srcb), .neg(b_neg_s), .y(b_mag_s));
  muldiv_abs #(.WIDTH(2*WIDTH)) u_abs_prod (.a(acc_q), .neg(neg_lo_q), .y(prod_s));

  // Shift-add: multiplier sits in the low half and is consumed LSB first.
  assign madd_s     = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign mul_next_s = {madd_s, acc_q[WIDTH-1:1]};

`ifdef MULDIV_DIV_EN
  logic                 is_div_q, is_div_d;
  logic                 dbz_q, dbz_d;
  logic                 neg_hi_q, neg_hi_d;
  logic [WIDTH:0]       part_s;
  logic [WIDTH-1:0]     diff_s, quo_s, rem_s;
  logic                 ge_s, div_zero_s;
  logic [2*WIDTH-1:0]   div_next_s;

  // Restoring division: remainder in the high half, dividend shifts out of
  // the low half while quotient bits shift in behind it.
  assign part_s     = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign ge_s       = part_s >= {1'b0, opnd_q};
  assign diff_s     = part_s[WIDTH-1:0] - opnd_q;
  assign div_next_s = {(ge_s ? diff_s : part_s[WIDTH-1:0]), acc_q[WIDTH-2:0], ge_s};
  assign div_zero_s = (opnd_q == {WIDTH{1'b0}});

  muldiv_abs #(.WIDTH(WIDTH)) u_abs_quo (.a(acc_q[WIDTH-1:0]), .neg(neg_lo_q), .y(quo_s));
  muldiv_abs #(.WIDTH(WIDTH)) u_abs_rem (.a(acc_q[2*WIDTH-1:WIDTH]), .neg(neg_hi_q), .y(rem_s));

  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    ready_d  = 1'b0;
    neg_lo_d = neg_lo_q;
`ifdef MULDIV_DIV_EN
    is_div_d = is_div_q;
    dbz_d    = dbz_q;
    neg_hi_d = neg_hi_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cancel || !start) begin
          state_d = ST_IDLE;
        end else begin
          case (op)
            OP_MULT, OP_MULTU: begin
              state_d  = ST_RUN;
              busy_d   = 1'b1;
              cnt_d    = CNT_LOAD;
              acc_d    = {{WIDTH{1'b0}}, b_mag_s};
              opnd_d   = a_mag_s;
              neg_lo_d = a_neg_s ^ b_neg_s;
`ifdef MULDIV_DIV_EN
              is_div_d = 1'b0;
              dbz_d    = 1'b0;
`endif
            end
`ifdef MULDIV_DIV_EN
            OP_DIV, OP_DIVU: begin
              state_d  = ST_RUN;
              busy_d   = 1'b1;
              cnt_d    = CNT_LOAD;
              acc_d    = {{WIDTH{1'b0}}, a_mag_s};
              opnd_d   = b_mag_s;
              neg_lo_d = a_neg_s ^ b_neg_s;
              neg_hi_d = a_neg_s;
              is_div_d = 1'b1;
              dbz_d    = 1'b0;
            end
`endif
            OP_MTHI: hi_d = srca;
            OP_MTLO: lo_d = srca;
            default: state_d = ST_IDLE;
          endcase
        end
      end
      ST_RUN: begin
        if (cancel) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
`ifdef MULDIV_DIV_EN
          acc_d = is_div_q ? div_next_s : mul_next_s;
`else
          acc_d = mul_next_s;
`endif
          if (cnt_q == {CW{1'b0}}) begin
            state_d = ST_FIX;
          end else begin
            cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
          end
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        if (cancel) begin
          ready_d = 1'b0;
        end else begin
          ready_d = 1'b1;
`ifdef MULDIV_DIV_EN
          if (is_div_q) begin
            hi_d  = rem_s;
            lo_d  = div_zero_s ? {WIDTH{1'b1}} : quo_s;
            dbz_d = div_zero_s;
          end else begin
            {hi_d, lo_d} = prod_s;
          end
`else
          {hi_d, lo_d} = prod_s;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CW{1'b0}};
      acc_q    <= {(2*WIDTH){1'b0}};
      opnd_q   <= {WIDTH{1'b0}};
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      neg_lo_q <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div_q <= 1'b0;
      dbz_q    <= 1'b0;
      neg_hi_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      neg_lo_q <= neg_lo_d;
`ifdef MULDIV_DIV_EN
      is_div_q <= is_div_d;
      dbz_q    <= dbz_d;
      neg_hi_q <= neg_hi_d;
`endif
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = busy_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed plus randomized bench for muldiv_unit (WIDTH=32) with an
// arithmetic reference model; follows MULDIV_DIV_EN like the design.
module tb_muldiv_unit;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic         clk = 1'b0;
  logic         reset, start, cancel;
  logic [2:0]   op;
  logic [W-1:0] srca, srcb, hi, lo;
  logic         busy, ready, div_by_zero;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] m_hi, m_lo;
  logic         m_dbz;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
    .cancel(cancel), .hi(hi), .lo(lo), .busy(busy), .ready(ready),
    .div_by_zero(div_by_zero)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic is_iter(input logic [2:0] o);
`ifdef MULDIV_DIV_EN
    return (o <= 3'd3);
`else
    return (o <= 3'd1);
`endif
  endfunction

  // Architectural effect of one accepted op on the model's HI/LO/dbz.
  task automatic model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      3'd0: begin p = sa * sb; {m_hi, m_lo} = p; m_dbz = 1'b0; end
      3'd1: begin p = ua * ub; {m_hi, m_lo} = p; m_dbz = 1'b0; end
`ifdef MULDIV_DIV_EN
      3'd2: begin
        if (b == 32'd0) begin
          m_lo = 32'hFFFFFFFF; m_hi = a; m_dbz = 1'b1;
        end else begin
          q = sa / sb; r = sa % sb;
          m_lo = q[31:0]; m_hi = r[31:0]; m_dbz = 1'b0;
        end
      end
      3'd3: begin
        if (b == 32'd0) begin
          m_lo = 32'hFFFFFFFF; m_hi = a; m_dbz = 1'b1;
        end else begin
          p = ua / ub; m_lo = p[31:0];
          p = ua % ub; m_hi = p[31:0];
          m_dbz = 1'b0;
        end
      end
`endif
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endtask

  task automatic do_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    int lat, busy_cnt;
    start = 1'b1; op = o; srca = a; srcb = b;
    tick();
    start = 1'b0;
    check("ready_clear", 64'(ready), 64'd0);
    if (is_iter(o)) begin
      check("busy_on", 64'(busy), 64'd1);
      check("dbz_cleared", 64'(div_by_zero), 64'd0);
      check("hi_hold_busy", 64'(hi), 64'(m_hi));
      model(o, a, b);
      lat = 0;
      busy_cnt = 1;
      for (int k = 1; k <= LAT + 5; k++) begin
        tick();
        if (ready) begin
          lat = k;
          break;
        end
        if (busy) busy_cnt++;
      end
      check("latency", 64'(lat), 64'(LAT));
      check("busy_cycles", 64'(busy_cnt), 64'(LAT));
      check("busy_at_ready", 64'(busy), 64'd0);
    end else begin
      model(o, a, b);
      check("busy_noiter", 64'(busy), 64'd0);
    end
    check("hi", 64'(hi), 64'(m_hi));
    check("lo", 64'(lo), 64'(m_lo));
    check("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
  endtask

  function automatic logic [W-1:0] pick(input int sel);
    case (sel)
      0: return W'($urandom);
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return W'($urandom_range(0, 20));
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    logic [W-1:0] h0, l0;
    logic         saw_ready;
    reset = 1'b1; start = 1'b0; cancel = 1'b0; op = 3'd0; srca = '0; srcb = '0;
    m_hi = '0; m_lo = '0; m_dbz = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);

    do_op(3'd0, 32'hFFFFFFFF, 32'd2);
    do_op(3'd1, 32'hFFFFFFFF, 32'd2);
    do_op(3'd2, 32'hFFFFFFF9, 32'd2);
    do_op(3'd3, 32'd100, 32'd7);
    do_op(3'd2, 32'h80000000, 32'hFFFFFFFF);
    do_op(3'd3, 32'h00001234, 32'd0);
    do_op(3'd0, 32'd3, 32'd5);
    do_op(3'd4, 32'hA5A5A5A5, 32'd0);
    do_op(3'd5, 32'h5A5A5A5A, 32'd0);
    do_op(3'd6, 32'h11111111, 32'd0);

    // Cancel in IDLE suppresses the simultaneous start.
    start = 1'b1; op = 3'd4; srca = 32'hDEADBEEF; cancel = 1'b1;
    tick();
    start = 1'b0; cancel = 1'b0;
    check("idle_cancel_hi", 64'(hi), 64'(m_hi));
    check("idle_cancel_busy", 64'(busy), 64'd0);

    // MULT cancelled at iteration 10; MTLO during busy is ignored.
    h0 = m_hi; l0 = m_lo;
    start = 1'b1; op = 3'd0; srca = 32'h12345678; srcb = 32'h9ABCDEF0;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    start = 1'b1; op = 3'd5; srca = 32'hCAFEF00D;
    tick();
    start = 1'b0;
    check("mtlo_busy_lo", 64'(lo), 64'(l0));
    check("mtlo_busy_busy", 64'(busy), 64'd1);
    for (int k = 6; k <= 9; k++) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cancel_busy", 64'(busy), 64'd0);
    check("cancel_hi", 64'(hi), 64'(h0));
    check("cancel_lo", 64'(lo), 64'(l0));
    saw_ready = 1'b0;
    for (int k = 0; k < LAT + 5; k++) begin
      if (ready) saw_ready = 1'b1;
      tick();
    end
    check("cancel_no_ready", 64'(saw_ready), 64'd0);
    check("cancel_hi_late", 64'(hi), 64'(h0));

    for (int i = 0; i < 24; i++) begin
      do_op(3'($urandom_range(0, 7)), pick($urandom_range(0, 3)), pick($urandom_range(0, 4)));
    end

    // Asynchronous reset mid-RUN.
    start = 1'b1; op = 3'd1; srca = 32'hFFFF0000; srcb = 32'h0000FFFF;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    #2;
    reset = 1'b1;
    #1;
    check("arst_hi", 64'(hi), 64'd0);
    check("arst_lo", 64'(lo), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_ready", 64'(ready), 64'd0);
    check("arst_dbz", 64'(div_by_zero), 64'd0);
    tick();
    reset = 1'b0;
    m_hi = '0; m_lo = '0; m_dbz = 1'b0;
    do_op(3'd0, 32'h80000000, 32'h80000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit with architectural HI/LO registers, sitting in the execute stage beside the ALU. It supersedes the fixed 32-bit multiplier. It adds the following:
- Signed and unsigned division.
- MTHI/MTLO writes.
- A cancel path for pipeline flushes.
- A busy/ready handshake that the hazard detector uses to stall MFHI/MFLO and back-to-back operations.

## Interface
- WIDTH, 32, operand width and width of HI and LO; must be even and ≥ 4.
- clk  in  1  pipeline clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  request; sampled only while busy=0.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others are a no-op.
- srca  in  WIDTH  multiplicand / dividend / MTHI-MTLO source.
- srcb  in  WIDTH  multiplier / divisor.
- cancel  in  1  abort the in-flight operation; HI/LO are left unchanged.
- hi  out  WIDTH  HI register; reset 0.
- lo  out  WIDTH  LO register; reset 0.
- busy  out  1  an iterative operation is in flight; reset 0.
- ready  out  1  one-cycle pulse when HI/LO were updated by an iterative operation; reset 0.
- div_by_zero  out  1  sticky until the next accepted start; set when a divide had srcb=0; reset 0.

## Operation
- FSM states: IDLE, RUN, FIX.
- IDLE, start with an iterative op (MULT, MULTU, DIV, DIVU):
  - Latch the operand magnitudes (absolute values for signed ops) and the result signs.
  - Clear div_by_zero, load counter=WIDTH-1, set busy, go to RUN.
- IDLE, start with MTHI/MTLO: write srca into HI/LO at that edge. busy stays 0 and ready stays 0.
- RUN performs one step per cycle:
  - Multiply step: shift-add into a 2*WIDTH accumulator.
  - Divide step: restoring division, one quotient bit per step.
  - When counter reaches 0, go to FIX.
- FIX:
  - Apply sign fix-up.
  - Write HI/LO, pulse ready, clear busy, return to IDLE.
- Multiply result: {hi,lo} = full 2*WIDTH product.
- Divide result: lo = quotient truncated toward zero; hi = remainder, which takes the dividend's sign.
- Divide by zero:
  - No iteration is skipped; latency is unchanged.
  - Result: lo = all ones, hi = srca, div_by_zero = 1.
- Signed overflow (most-negative / -1): lo = most-negative, hi = 0. This result comes out of the magnitude algorithm naturally.
- Start while busy=1 is ignored. This includes MTHI/MTLO; the hazard unit must stall them.
- cancel has priority over every FSM transition.
  - In RUN or FIX it returns the FSM to IDLE with no HI/LO write, and ready stays 0.
  - In IDLE it suppresses the start sampled in the same cycle.
- Reset mid-operation: the FSM goes to IDLE immediately (asynchronously) and all outputs go to their reset values.

## Timing
- start accepted at edge N:
  - busy is high from edge N through edge N+WIDTH+1.
  - Iterations run at edges N+1 through N+WIDTH.
  - FIX writes HI/LO at edge N+WIDTH+1.
  - ready is high for exactly the cycle after edge N+WIDTH+1.
- Latency: WIDTH+1 edges from the accepting edge to the HI/LO update, i.e. 33 for WIDTH=32.
- A new start may be accepted in the cycle where ready=1, because busy=0 in that cycle. This gives back-to-back throughput of one operation per WIDTH+2 cycles.
- MTHI/MTLO: one-edge latency; the new value is visible in the cycle after the accepting edge.
- hi, lo, busy, ready and div_by_zero are all registered outputs with no combinational path from inputs.

## Configuration
- MULDIV_DIV_EN defined:
  - Division datapath compiled in; DIV and DIVU behave as specified above.
- MULDIV_DIV_EN undefined:
  - Divide logic removed.
  - op 010/011 are no-ops: not accepted, busy stays 0, HI/LO are unchanged, div_by_zero is tied to 0.
  - Multiply, MTHI and MTLO timing are unchanged.

## Structure
- Shared package muldiv_pkg holds:
  - The op encoding constants.
  - The FSM state enum.
  - The function for the latency constant WIDTH+1.
- One sub-module, muldiv_abs: parametrised WIDTH, combinational conditional two's-complement negate. It is instantiated for:
  - Taking operand magnitudes at start.
  - Result negation in FIX.
- The counter, accumulator and quotient/remainder registers stay in muldiv_unit.

## Test plan
- WIDTH=32:
  - MULT srca=0xFFFFFFFF, srcb=2 → hi=0xFFFFFFFF, lo=0xFFFFFFFE.
  - ready pulses 34 cycles after the start cycle.
  - busy is high for 33 cycles.
- MULTU srca=0xFFFFFFFF, srcb=2 → hi=0x00000001, lo=0xFFFFFFFE.
- DIV -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100/7 → lo=14, hi=2.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU srca=0x1234, srcb=0 → lo=0xFFFFFFFF, hi=0x1234, div_by_zero=1; a following MULT start clears div_by_zero.
- MTHI 0xA5A5A5A5, then MTLO 0x5A5A5A5A:
  - Each write is visible the next cycle, with ready=0.
  - An MTLO asserted while busy is ignored.
- MULT started; cancel at iteration 10:
  - busy drops at the next edge; HI/LO retain their prior values; no ready pulse.
  - A start asserted during busy is ignored.
  - reset asserted mid-RUN clears all outputs without waiting for a clock edge.
